commit_arb: RTL and testbench
=============================

# commit_arb

Round-robin arbiter and sequencer that shares one `commit` unit between `N_REQ` requesters. It accepts a 32-bit commit word from the winning requester and forwards it on the `commit` req channel. It then holds the grant until the matching `commit` rsp handshake completes and routes that response back to the owner. Only one transaction is outstanding at a time. A watchdog aborts a transaction whose response never arrives.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 32: commit word width.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort, ≥2.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_vaild` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept; one-hot or zero.
- `r_in` in N_REQ*W: requester i's word is `r_in[i*W +: W]`.
- `rsp_vaild` out N_REQ: per-requester response valid; one-hot or zero.
- `rsp_ready` in N_REQ: per-requester response ready.
- `cm_req_vaild` out 1: request valid to `commit`.
- `cm_req_ready` in 1: ready from `commit`.
- `cm_r_in` out W: held word to `commit`.
- `cm_rsp_vaild` in 1: response valid from `commit`.
- `cm_rsp_ready` out 1: response ready to `commit`.
- `owner` out clog2(N_REQ): index of the current grant holder.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- FSM states and encoding: IDLE=0, ISSUE=1, WAIT=2.
- **IDLE**
  - Combinational round-robin search over `req_vaild`, starting at pointer `ptr` and wrapping modulo N_REQ.
  - First asserted index k wins; `req_ready[k]`=1 that cycle. The handshake completes that cycle.
  - On that edge: latch `r_in[k]` into the hold register, `owner`←k, go to ISSUE.
  - No `req_vaild` asserted: stay in IDLE, all `req_ready`=0.
- **ISSUE**
  - `cm_req_vaild`=1 and `cm_r_in`=hold register, both stable until `cm_req_ready`.
  - On `cm_req_vaild`&&`cm_req_ready`: go to WAIT and clear the watchdog counter to 0.
- **WAIT**
  - `rsp_vaild[owner]`=`cm_rsp_vaild`; `cm_rsp_ready`=`rsp_ready[owner]`.
  - All other `rsp_vaild` bits are 0, and `req_ready` is all 0.
  - On the handshake (`cm_rsp_vaild`&&`cm_rsp_ready`): `ptr`←(owner+1) mod N_REQ, go to IDLE.
  - Otherwise the counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without a handshake: pulse `timeout_err`, `ptr`←(owner+1) mod N_REQ, go to IDLE.
  - A late `cm_rsp_vaild` seen in IDLE is dropped: `cm_rsp_ready`=0 in IDLE/ISSUE, and nothing is forwarded.
- **Simultaneous events**
  - A handshake on the same cycle the counter hits TIMEOUT-1 counts as a normal completion; no `timeout_err`.
- **Requester behaviour**
  - A requester must not withdraw `req_vaild` before it sees `req_ready`. Withdrawal is tolerated: that requester simply loses arbitration.
  - Words from non-winning requesters are ignored.
- **Reset**
  - Values: state=IDLE, `ptr`=0, `owner`=0, hold register=0, counter=0.
  - All outputs return to 0 on the next edge, including mid-ISSUE and mid-WAIT.
  - An aborted transaction is never resumed.

## Timing
- Reset values of outputs: all zero (`req_ready`, `rsp_vaild`, `cm_req_vaild`, `cm_r_in`, `cm_rsp_ready`, `owner`, `busy`, `timeout_err`).
- Accept to `cm_req_vaild`: 1 cycle, so `cm_req_vaild` rises on the edge after the `req_ready` cycle.
- Decode paths:
  - `rsp_vaild`/`cm_rsp_ready` are combinational from the state/owner registers and the inputs. No added latency; they are not registered.
  - `req_ready` is combinational from `req_vaild`, `ptr` and the state.
- Throughput:
  - A zero-wait `commit` completes one transaction per 3 cycles: IDLE accept, ISSUE, WAIT.
  - The next accept is possible on the cycle after the rsp handshake.
- `timeout_err` is registered: high exactly one cycle, the first cycle back in IDLE.

## Test plan
- **Single requester:** reset, then `req_vaild[2]`=1 with word 0x44C7D916, `cm_req_ready`=1, `cm_rsp_vaild` one cycle after WAIT entry, `rsp_ready`=all 1.
  - `req_ready`=0b0100 for one cycle.
  - `cm_r_in`=0x44C7D916 on the next cycle.
  - `rsp_vaild`=0b0100 during the rsp handshake; `ptr`=3 afterwards.
- **Fairness:** all four `req_vaild` held high, zero-wait `commit`.
  - Grant order 0,1,2,3,0 on accepts spaced 3 cycles apart.
- **Backpressure:** `cm_req_ready` low for 5 cycles in ISSUE.
  - `cm_req_vaild` and `cm_r_in` stay stable for the whole stall.
  - `busy`=1 throughout; no new `req_ready`.
- **Response stall:** `rsp_ready[owner]`=0 for 3 cycles while `cm_rsp_vaild`=1.
  - `cm_rsp_ready`=0 for those cycles; completion on the first cycle `rsp_ready` rises.
- **Watchdog:** TIMEOUT=8, no `cm_rsp_vaild`.
  - `timeout_err` pulses once, 8 cycles after WAIT entry; state returns to IDLE and `ptr` advances.
  - A handshake landing exactly on count 7 completes normally with no pulse.
- **Reset mid-WAIT:** assert `reset` for one cycle while in WAIT.
  - All outputs read 0 on the next edge; state=IDLE, `ptr`=0.
  - A subsequent `cm_rsp_vaild` is not forwarded.

Source files
------------

// File: rtl/commit_arb.sv
// Round-robin arbiter that shares one commit unit between N_REQ requesters,
// holding the grant until the routed response completes or the watchdog aborts.
module commit_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_vaild,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         r_in,
  output logic [N_REQ-1:0]           rsp_vaild,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic                       cm_req_vaild,
  input  logic                       cm_req_ready,
  output logic [W-1:0]               cm_r_in,
  input  logic                       cm_rsp_vaild,
  output logic                       cm_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] LAST    = PW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, win, idx, owner_inc;
  logic            found, req_hs, rsp_hs, expire;
  logic [W-1:0]    hold;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = r_in[g*W +: W];
  end

  // Walk from ptr with wrap; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_vaild[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + PW'(1);
    end
  end

  // Grant is withheld while reset is high so no accept can be lost to reset.
  assign req_hs    = (state == IDLE) && found && !reset;
  assign rsp_hs    = (state == WAIT) && cm_rsp_vaild && rsp_ready[owner];
  assign expire    = (state == WAIT) && !rsp_hs && (cnt == CNT_MAX);
  assign owner_inc = (owner == LAST) ? '0 : owner + PW'(1);
  assign busy      = (state != IDLE);
  assign cm_r_in   = hold;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready    = '0;
    rsp_vaild    = '0;
    cm_req_vaild = 1'b0;
    cm_rsp_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req_hs) begin
          req_ready[win] = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        cm_req_vaild = 1'b1;
        if (cm_req_ready) state_next = WAIT;
      end
      WAIT: begin
        rsp_vaild[owner] = cm_rsp_vaild;
        cm_rsp_ready     = rsp_ready[owner];
        if (rsp_hs || expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      owner       <= '0;
      hold        <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (req_hs) begin
        hold  <= words[win];
        owner <= win;
      end
      if (state == ISSUE && cm_req_ready)
        cnt <= '0;
      else if (state == WAIT && !rsp_hs && !expire)
        cnt <= cnt + CW'(1);
      if (rsp_hs || expire)
        ptr <= owner_inc;
    end
  end

endmodule

// File: tb/tb_commit_arb.sv
// Directed bench for commit_arb: single request, fairness, stalls, watchdog, reset.
module tb_commit_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_vaild, req_ready, rsp_vaild, rsp_ready;
  logic [127:0] r_in;
  logic         cm_req_vaild, cm_req_ready, cm_rsp_vaild, cm_rsp_ready;
  logic [31:0]  cm_r_in;
  logic [1:0]   owner;
  logic         busy, timeout_err;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] word_tab [4] = '{32'h1111_0A0A, 32'h2222_1B1B, 32'h44C7_D916, 32'h8888_3D3D};
  int          grant_tab [5] = '{0, 1, 2, 3, 0};

  commit_arb #(.N_REQ(4), .W(32), .TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_vaild    (req_vaild),
    .req_ready    (req_ready),
    .r_in         (r_in),
    .rsp_vaild    (rsp_vaild),
    .rsp_ready    (rsp_ready),
    .cm_req_vaild (cm_req_vaild),
    .cm_req_ready (cm_req_ready),
    .cm_r_in      (cm_r_in),
    .cm_rsp_vaild (cm_rsp_vaild),
    .cm_rsp_ready (cm_rsp_ready),
    .owner        (owner),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed stalled expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1;
    req_vaild = '0;
    rsp_ready = '0;
    cm_req_ready = 1'b0;
    cm_rsp_vaild = 1'b0;
    for (int i = 0; i < 4; i++) r_in[i*32 +: 32] = word_tab[i];

    // Reset state
    cyc; cyc; settle;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_cm_req_vaild", 32'(cm_req_vaild), 32'h0);
    check("rst_cm_r_in", cm_r_in, 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    cyc;

    // Single requester 2
    req_vaild = 4'b0100; cm_req_ready = 1'b1; rsp_ready = 4'b1111;
    settle;
    check("single_req_ready", 32'(req_ready), 32'h4);
    cyc; req_vaild = '0; settle;
    check("single_cm_req_vaild", 32'(cm_req_vaild), 32'h1);
    check("single_cm_r_in", cm_r_in, 32'h44C7_D916);
    check("single_owner", 32'(owner), 32'h2);
    check("single_no_ready", 32'(req_ready), 32'h0);
    cyc; settle;
    check("single_wait_idle_rsp", 32'(rsp_vaild), 32'h0);
    check("single_wait_busy", 32'(busy), 32'h1);
    cyc; cm_rsp_vaild = 1'b1; settle;
    check("single_rsp_vaild", 32'(rsp_vaild), 32'h4);
    check("single_cm_rsp_ready", 32'(cm_rsp_ready), 32'h1);
    cyc; cm_rsp_vaild = 1'b0; settle;
    check("single_done_busy", 32'(busy), 32'h0);
    check("single_ptr", 32'(dut.ptr), 32'h3);

    // Fairness from a fresh pointer, zero-wait commit
    reset = 1'b1; cyc; reset = 1'b0;
    req_vaild = 4'b1111; cm_rsp_vaild = 1'b1;
    for (int t = 0; t < 5; t++) begin
      settle;
      check("fair_req_ready", 32'(req_ready), 32'(1) << grant_tab[t]);
      cyc; settle;
      check("fair_owner", 32'(owner), 32'(grant_tab[t]));
      check("fair_cm_r_in", cm_r_in, word_tab[grant_tab[t]]);
      cyc; settle;
      check("fair_rsp_vaild", 32'(rsp_vaild), 32'(1) << grant_tab[t]);
      cyc;
    end
    req_vaild = '0; cm_rsp_vaild = 1'b0;

    // Backpressure in ISSUE (ptr=1, requester 3 wins)
    req_vaild = 4'b1000; settle;
    check("bp_req_ready", 32'(req_ready), 32'h8);
    cyc; req_vaild = 4'b1111; cm_req_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      settle;
      check("bp_cm_req_vaild", 32'(cm_req_vaild), 32'h1);
      check("bp_cm_r_in", cm_r_in, 32'h8888_3D3D);
      check("bp_busy", 32'(busy), 32'h1);
      check("bp_no_ready", 32'(req_ready), 32'h0);
      cyc;
    end
    cm_req_ready = 1'b1; req_vaild = '0; cyc;

    // Response stall while owner 3 is not ready
    cm_rsp_vaild = 1'b1; rsp_ready = 4'b0111;
    for (int s = 0; s < 3; s++) begin
      settle;
      check("rs_cm_rsp_ready", 32'(cm_rsp_ready), 32'h0);
      check("rs_rsp_vaild", 32'(rsp_vaild), 32'h8);
      check("rs_busy", 32'(busy), 32'h1);
      cyc;
    end
    rsp_ready = 4'b1000; settle;
    check("rs_release", 32'(cm_rsp_ready), 32'h1);
    cyc; cm_rsp_vaild = 1'b0; rsp_ready = 4'b1111; settle;
    check("rs_done_busy", 32'(busy), 32'h0);
    check("rs_ptr", 32'(dut.ptr), 32'h0);

    // Watchdog abort: no response at all
    req_vaild = 4'b0001; settle;
    check("wd_req_ready", 32'(req_ready), 32'h1);
    cyc; req_vaild = '0;
    cyc;
    for (int s = 0; s < 8; s++) begin
      settle;
      check("wd_wait_busy", 32'(busy), 32'h1);
      check("wd_no_pulse", 32'(timeout_err), 32'h0);
      cyc;
    end
    settle;
    check("wd_pulse", 32'(timeout_err), 32'h1);
    check("wd_idle", 32'(busy), 32'h0);
    check("wd_ptr", 32'(dut.ptr), 32'h1);
    cyc; settle;
    check("wd_pulse_end", 32'(timeout_err), 32'h0);

    // Late response in IDLE is dropped
    cm_rsp_vaild = 1'b1; settle;
    check("late_cm_rsp_ready", 32'(cm_rsp_ready), 32'h0);
    check("late_rsp_vaild", 32'(rsp_vaild), 32'h0);
    cm_rsp_vaild = 1'b0;

    // Handshake exactly on the last count completes normally
    req_vaild = 4'b0010; settle;
    check("edge_req_ready", 32'(req_ready), 32'h2);
    cyc; req_vaild = '0;
    cyc;
    for (int s = 0; s < 7; s++) cyc;
    settle;
    check("edge_cnt", 32'(dut.cnt), 32'h7);
    cm_rsp_vaild = 1'b1; settle;
    check("edge_rsp_vaild", 32'(rsp_vaild), 32'h2);
    cyc; cm_rsp_vaild = 1'b0; settle;
    check("edge_no_pulse", 32'(timeout_err), 32'h0);
    check("edge_idle", 32'(busy), 32'h0);
    check("edge_ptr", 32'(dut.ptr), 32'h2);
    cyc; settle;
    check("edge_no_pulse_later", 32'(timeout_err), 32'h0);

    // Reset mid-WAIT
    req_vaild = 4'b0100; settle;
    check("mr_req_ready", 32'(req_ready), 32'h4);
    cyc; req_vaild = '0;
    cyc; settle;
    check("mr_in_wait", 32'(busy), 32'h1);
    reset = 1'b1; cyc; settle;
    check("mr_req_ready0", 32'(req_ready), 32'h0);
    check("mr_rsp_vaild0", 32'(rsp_vaild), 32'h0);
    check("mr_cm_req_vaild0", 32'(cm_req_vaild), 32'h0);
    check("mr_cm_r_in0", cm_r_in, 32'h0);
    check("mr_cm_rsp_ready0", 32'(cm_rsp_ready), 32'h0);
    check("mr_owner0", 32'(owner), 32'h0);
    check("mr_busy0", 32'(busy), 32'h0);
    check("mr_timeout0", 32'(timeout_err), 32'h0);
    check("mr_ptr0", 32'(dut.ptr), 32'h0);
    reset = 1'b0; cm_rsp_vaild = 1'b1; settle;
    check("mr_late_rsp", 32'(rsp_vaild), 32'h0);
    check("mr_late_cm_ready", 32'(cm_rsp_ready), 32'h0);
    cyc; settle;
    check("mr_stay_idle", 32'(busy), 32'h0);
    cm_rsp_vaild = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
